// File: rtl/monociclo_pkg.sv
// Shared definitions for the single-cycle core run controller.
//   run_state_t     : run controller FSM encoding (also exported on state_o)
//   HALT_JAL_SELF   : default halt encoding, jal x0,0 (a branch onto itself)
//   INSTR_W_DEFAULT : default instruction width
package monociclo_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2,
    TIMEOUT    = 2'd3
  } run_state_t;

  localparam logic [31:0] HALT_JAL_SELF   = 32'h0000_006F;
  localparam int unsigned INSTR_W_DEFAULT = 32;

endpackage

// File: rtl/monociclo_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, forces the count to 0
//   clr_i   : synchronous clear, forces the count to 0 (wins over en_i)
//   en_i    : count one step this cycle
//   count_o : current count; sticks at all-ones instead of wrapping
module monociclo_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/monociclo_run_ctrl.sv
// Run controller for the single-cycle core: holds the core in reset for RESET_CYCLES cycles,
// then enables it until a halt instruction is fetched or the MAX_CYCLES budget is spent
// (MAX_CYCLES=0 means no budget). restart re-runs the program once it has stopped.
// Optional single-step mode is compiled in with `define MONOCICLO_RUN_CTRL_STEP_EN.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   instr       : instruction currently fetched by the core (only looked at in RUN)
//   restart     : pulse, re-runs the program from HALTED/TIMEOUT
//   step_mode   : (STEP_EN only) 1 = enable the core only one cycle per step pulse
//   step        : (STEP_EN only) step request
//   core_reset  : reset to the core
//   core_en     : clock enable to the core
//   cycle_count : enabled cycles since the last (re)start, saturating
//   done        : program stopped (halt or timeout)
//   timeout     : program stopped because the budget ran out
//   state_o     : FSM state for debug
module monociclo_run_ctrl
  import monociclo_pkg::*;
#(
  parameter int unsigned          RESET_CYCLES = 1,
  parameter int unsigned          MAX_CYCLES   = 10,
  parameter int unsigned          CNT_W        = 32,
  parameter int unsigned          INSTR_W      = INSTR_W_DEFAULT,
  parameter logic [INSTR_W-1:0]   HALT_INSTR   = INSTR_W'(HALT_JAL_SELF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               restart,
`ifdef MONOCICLO_RUN_CTRL_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               core_reset,
  output logic               core_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               timeout,
  output logic [1:0]         state_o
);

  localparam logic [31:0] RstLast = 32'(RESET_CYCLES - 1);

  run_state_t  state_q;
  logic [31:0] rst_cnt_q;
  logic        core_reset_q, core_en_q, done_q, timeout_q;

  logic        run_en;     // core_en value for the next cycle while staying in RUN
  logic        is_halt;
  logic        budget_hit;
  logic        cnt_en, cnt_clr;

`ifdef MONOCICLO_RUN_CTRL_STEP_EN
  assign run_en = step_mode ? step : 1'b1;
`else
  assign run_en = 1'b1;
`endif

  assign is_halt    = (instr == HALT_INSTR);
  assign budget_hit = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

  // core_en_q marks the cycle the core actually advances; only those cycles are counted and
  // checked for halt/budget, which keeps step mode and free-run on the same path.
  always_comb begin
    cnt_en  = (state_q == RUN) && core_en_q;
    cnt_clr = ((state_q == HALTED) || (state_q == TIMEOUT)) && restart;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_HOLD;
      rst_cnt_q    <= '0;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (rst_cnt_q == RstLast) begin
            state_q      <= RUN;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b0;
            core_en_q    <= run_en;
          end else begin
            rst_cnt_q <= rst_cnt_q + 32'd1;
          end
        end
        RUN: begin
          // Halt is checked first so it wins over a coincident budget expiry.
          if (core_en_q && is_halt) begin
            state_q   <= HALTED;
            core_en_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (core_en_q && budget_hit) begin
            state_q   <= TIMEOUT;
            core_en_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            core_en_q <= run_en;
          end
        end
        HALTED, TIMEOUT: begin
          if (restart) begin
            state_q      <= RESET_HOLD;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= RESET_HOLD;
        end
      endcase
    end
  end

  monociclo_sat_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycle_count)
  );

  assign core_reset = core_reset_q;
  assign core_en    = core_en_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign state_o    = state_q;

endmodule

// File: doc/monociclo_run_ctrl.md
Name: monociclo_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle core.
- Sequences the core's reset, gates execution through a clock enable, and counts executed cycles.
- Stops on a halt instruction or a cycle budget.
- Bench and FPGA top drive the core through this block instead of hard-coded delays; a debug single-step mode is optional.

Parameters:
- RESET_CYCLES, 1: cycles core_reset stays high after leaving reset or restart; legal range ≥1.
- MAX_CYCLES, 10: cycle budget; 0 means unlimited (no timeout).
- CNT_W, 32: width of cycle_count.
- INSTR_W, 32: instruction width.
- HALT_INSTR, 32'h0000_006F: halt encoding (jal x0,0, a self-loop).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  INSTR_W  instruction currently fetched by the core
- restart  in  1  single-cycle pulse; re-runs the program after it has stopped
- core_reset  out  1  reset to the core
- core_en  out  1  clock enable to the core; core state advances only when 1
- cycle_count  out  CNT_W  number of enabled cycles since the last (re)start
- done  out  1  program stopped (halt or timeout)
- timeout  out  1  stopped because the budget ran out
- state_o  out  2  current FSM state (debug)

Behaviour:
- All outputs are registered.
- reset=1, values on the next edge:
  - state=RESET_HOLD, rst_cnt=0, core_reset=1, core_en=0, cycle_count=0, done=0, timeout=0.
- FSM states: RESET_HOLD=0, RUN=1, HALTED=2, TIMEOUT=3.
- RESET_HOLD:
  - core_reset=1, core_en=0; rst_cnt increments each cycle.
  - When rst_cnt==RESET_CYCLES-1, go to RUN. core_reset is high for exactly RESET_CYCLES cycles after reset is released.
- RUN:
  - core_reset=0, core_en=1; cycle_count increments each cycle and saturates at 2^CNT_W-1.
  - If instr==HALT_INSTR → HALTED. The halt cycle is counted, and core_en is 0 from the next cycle.
  - Else if MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 → TIMEOUT. Exactly MAX_CYCLES enabled cycles occur.
  - If halt and budget expiry coincide, HALTED wins and timeout stays 0.
- HALTED: core_en=0, done=1, timeout=0; cycle_count holds.
- TIMEOUT: core_en=0, done=1, timeout=1; cycle_count holds.
- restart:
  - In HALTED/TIMEOUT, restart=1 → RESET_HOLD. Clears cycle_count, done, timeout and rst_cnt; core_reset=1 on the next cycle.
  - Ignored in RESET_HOLD and RUN.
- reset mid-RUN: aborts immediately to the reset values above; there is no partial count retention.
- instr is sampled only in RUN. Its value in other states has no effect.

Optional Feature:
- Macro: MONOCICLO_RUN_CTRL_STEP_EN.
- Defined:
  - Adds input ports step_mode (1) and step (1).
  - In RUN with step_mode=1, core_en is 1 only in the cycle after a step pulse, i.e. exactly one enabled cycle per pulse. A held step gives one cycle per clock.
  - cycle_count, halt detection and budget are evaluated only on enabled cycles.
  - step_mode=0 behaves as free-run.
- Undefined: the ports do not exist and the block always free-runs.

Decomposition:
- Shared package monociclo_pkg holds:
  - typedef enum logic [1:0] run_state_t {RESET_HOLD, RUN, HALTED, TIMEOUT}
  - localparam HALT_JAL_SELF = 32'h0000_006F
  - INSTR_W default.
- One natural sub-module, monociclo_sat_counter (parametrised width; enable, clear, saturation), used for cycle_count.
- rst_cnt stays inline.

Test Plan:
- Reset then release, RESET_CYCLES=3 → core_reset high exactly 3 cycles after release, then core_en=1 and cycle_count 1,2,3…
- MAX_CYCLES=10, instr never HALT_INSTR → after 10 enabled cycles: state=TIMEOUT, done=1, timeout=1, cycle_count=10, core_en=0.
- instr=32'h0000_006F on the 5th RUN cycle → HALTED, cycle_count=5, done=1, timeout=0; core_en falls the next cycle.
- Halt on the 10th cycle with MAX_CYCLES=10 → HALTED, timeout=0, cycle_count=10.
- restart pulse in TIMEOUT → count/done/timeout cleared, core_reset re-asserted RESET_CYCLES cycles, run repeats identically. A restart pulse during RUN → no effect.
- reset asserted at RUN cycle 4 → next edge core_reset=1, cycle_count=0. With STEP_EN and step_mode=1, three step pulses → cycle_count=3, exactly 3 core_en cycles.
